// File: rtl/eth_helper_pkg.sv
// Shared types for the R-channel stream decoder: stream type tags, AXI RRESP codes, decoder states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package eth_helper_pkg;

  // Type tags carried in the top bits of a stream header word.
  typedef enum logic [2:0] {
    STREAM_AW = 3'b000,
    STREAM_W  = 3'b001,
    STREAM_R  = 3'b010,
    STREAM_AR = 3'b011,
    STREAM_B  = 3'b100
  } stream_type_e;

  // AXI read response codes.
  typedef enum logic [1:0] {
    RRESP_OKAY   = 2'b00,
    RRESP_EXOKAY = 2'b01,
    RRESP_SLVERR = 2'b10,
    RRESP_DECERR = 2'b11
  } rresp_e;

  // Decoder FSM: waiting for a header, forwarding payload, or discarding a bad packet.
  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    SKIP = 2'd2
  } dec_state_e;

  localparam int SKID_DEPTH = 2;

  // Only SLVERR and DECERR are treated as in-band error codes.
  function automatic logic is_err_resp(input logic [1:0] code);
    return (code == RRESP_SLVERR) || (code == RRESP_DECERR);
  endfunction

endpackage

// File: rtl/stream_to_axi_r_if.sv
// Bundles the inbound stream port and the outbound AXI R port of the decoder.
// Latency: none (wiring only).
// Backpressure: s_ready toward the stream source, m_rready from the AXI sink.
interface stream_to_axi_r_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 32,
  parameter int USER_WIDTH = 64
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [DATA_WIDTH-1:0] s_data;
  logic [ID_WIDTH-1:0]   m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic [USER_WIDTH-1:0] m_ruser;
  logic                  m_rvalid;
  logic                  m_rready;

  // Decoder side: consumes the stream, drives AXI R.
  modport slave (
    input  s_valid, s_last, s_data, m_rready,
    output s_ready, m_rid, m_rdata, m_rresp, m_rlast, m_ruser, m_rvalid
  );

  // Environment side: sources the stream, sinks AXI R.
  modport master (
    output s_valid, s_last, s_data, m_rready,
    input  s_ready, m_rid, m_rdata, m_rresp, m_rlast, m_ruser, m_rvalid
  );
endinterface

// File: rtl/axi_r_skid.sv
// Two-entry valid/ready buffer holding fully formed AXI R beats; outputs come straight from storage.
// Latency: a push appears at the output the following cycle when the buffer was empty.
// Backpressure: o_full_nxt predicts fullness after this cycle so the producer can register its ready.
module axi_r_skid
  import eth_helper_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat,
  input  logic             i_rdy,
  output logic             o_full_nxt
);

  logic [WIDTH-1:0] r_mem [SKID_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  assign w_full     = (r_cnt == 2'(SKID_DEPTH));
  assign w_push     = i_vld && !w_full;
  assign w_pop      = o_vld && i_rdy;
  assign w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign o_full_nxt = (w_cnt_nxt == 2'(SKID_DEPTH));
  assign o_vld      = (r_cnt != 2'd0);
  assign o_dat      = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Storage needs no reset: contents are only observed while o_vld is high.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/stream_to_axi_r.sv
// Rebuilds AXI R bursts from {header, payload...} stream packets; bad packets are dropped with a proto_err pulse.
// Latency: a payload beat accepted in cycle N is presented on m_rvalid in cycle N+1 when the skid is empty.
// Backpressure: registered s_ready drops in DATA once the 2-entry skid will be full; no comb path from m_rready.
module stream_to_axi_r
  import eth_helper_pkg::*;
#(
  parameter int                           DATA_WIDTH        = 128,
  parameter int                           ID_WIDTH          = 32,
  parameter int                           USER_WIDTH        = 64,
  parameter int                           STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = STREAM_R,
  parameter int                           DECODE_ERR        = 1
) (
  input  logic                clk,
  input  logic                reset,
  stream_to_axi_r_if.slave    bus,
  output logic                busy,
  output logic                proto_err
);

  localparam int SKID_W = ID_WIDTH + DATA_WIDTH + 3;

  dec_state_e                   r_state;
  logic [ID_WIDTH-1:0]          r_id_q;
  logic                         r_proto_err;
  logic                         r_s_ready;

  logic                         w_accept;
  logic [STREAM_TYPE_WIDTH-1:0] w_tag;
  logic                         w_tag_ok;
  logic                         w_mid_zero;
  logic [1:0]                   w_code;
  logic                         w_is_err;
  logic [1:0]                   w_rresp;
  logic [DATA_WIDTH-1:0]        w_rdata;
  logic                         w_push;
  logic [SKID_W-1:0]            w_push_dat;
  logic                         w_head_vld;
  logic [SKID_W-1:0]            w_head_dat;
  logic                         w_full_nxt;

  assign w_accept   = bus.s_valid && r_s_ready;
  assign w_tag      = bus.s_data[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH];
  assign w_tag_ok   = (w_tag == STREAM_TYPE);
  assign w_mid_zero = (bus.s_data[DATA_WIDTH-STREAM_TYPE_WIDTH-1:2] == '0);
  assign w_code     = bus.s_data[1:0];

  // In-band error word: own type tag, zero body, SLVERR/DECERR code in the low bits.
  // A real payload that happens to look like this is reported as an error too.
  assign w_is_err   = (DECODE_ERR != 0) && w_tag_ok && w_mid_zero && is_err_resp(w_code);
  assign w_rresp    = w_is_err ? w_code : RRESP_OKAY;
  assign w_rdata    = w_is_err ? '0 : bus.s_data;

  assign w_push     = w_accept && (r_state == DATA);
  assign w_push_dat = {r_id_q, w_rdata, w_rresp, bus.s_last};

  axi_r_skid #(
    .WIDTH (SKID_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_vld      (w_push),
    .i_dat      (w_push_dat),
    .o_vld      (w_head_vld),
    .o_dat      (w_head_dat),
    .i_rdy      (bus.m_rready),
    .o_full_nxt (w_full_nxt)
  );

  assign bus.m_rvalid = w_head_vld;
  assign bus.m_rid    = w_head_dat[SKID_W-1 -: ID_WIDTH];
  assign bus.m_rdata  = w_head_dat[DATA_WIDTH+2 -: DATA_WIDTH];
  assign bus.m_rresp  = w_head_dat[2:1];
  assign bus.m_rlast  = w_head_vld && w_head_dat[0];
  assign bus.m_ruser  = {USER_WIDTH{1'b0}};
  assign bus.s_ready  = r_s_ready;

  assign busy         = (r_state != HDR);
  assign proto_err    = r_proto_err;

  // Packet framing FSM with registered s_ready, latched burst ID and proto_err pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HDR;
      r_id_q      <= '0;
      r_proto_err <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_proto_err <= 1'b0;
      r_s_ready   <= 1'b1;
      case (r_state)
        HDR: begin
          if (w_accept) begin
            if (bus.s_last) begin
              // Header-only packet: nothing to emit, stay framed on headers.
              r_proto_err <= 1'b1;
            end else if (w_tag_ok) begin
              r_id_q    <= bus.s_data[ID_WIDTH-1:0];
              r_state   <= DATA;
              r_s_ready <= !w_full_nxt;
            end else begin
              r_proto_err <= 1'b1;
              r_state     <= SKIP;
            end
          end
        end
        DATA: begin
          if (w_accept && bus.s_last) begin
            r_state <= HDR;
          end else begin
            r_s_ready <= !w_full_nxt;
          end
        end
        SKIP: begin
          if (w_accept && bus.s_last) r_state <= HDR;
        end
        default: r_state <= HDR;
      endcase
    end
  end

endmodule
